// File: rtl/tiny_proc_sequencer_if.sv
// Host, program-load and processor-core signals of the tiny processor run controller.
// The sequencer uses the slave modport; the host/bench side uses master.
interface tiny_proc_sequencer_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int GPIO_W  = 4,
    parameter int CNT_W   = 16
);
    // Program load handshake
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;

    // Run control
    logic               start;
    logic [CNT_W-1:0]   run_cycles;
    logic               pause;
    logic               step;
    logic               stop;

    // Processor side
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               proc_reset_p;
    logic               proc_ce;
    logic [GPIO_W-1:0]  proc_gpio_out;

    // Status
    logic [GPIO_W-1:0]  gpio_snapshot;
    logic [CNT_W-1:0]   cycles_run;
    logic               busy;
    logic               done;
    logic               load_error;
    logic               halted;

    modport master (
        output load_valid, load_data, load_last, start, run_cycles, pause, step, stop,
               proc_gpio_out,
        input  load_ready, imem_we, imem_addr, imem_wdata, proc_reset_p, proc_ce,
               gpio_snapshot, cycles_run, busy, done, load_error, halted
    );

    modport slave (
        input  load_valid, load_data, load_last, start, run_cycles, pause, step, stop,
               proc_gpio_out,
        output load_ready, imem_we, imem_addr, imem_wdata, proc_reset_p, proc_ce,
               gpio_snapshot, cycles_run, busy, done, load_error, halted
    );
endinterface

// File: rtl/tiny_proc_sequencer.sv
// Run controller for the 4-bit tiny processor: program load, core reset/clock-enable gating,
// cycle counting and GPIO snapshot. Optional halt detection under TINY_SEQ_HALT_DETECT_EN.
module tiny_proc_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int INSTR_W     = 8,
    parameter int GPIO_W      = 4,
    parameter int RST_CYCLES  = 3,
    parameter int CNT_W       = 16,
    parameter int HALT_WINDOW = 8
) (
    input logic                  i_clock,
    input logic                  i_reset_p,
    tiny_proc_sequencer_if.slave io_seq
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(2 ** ADDR_W);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StPause,
        StStep,
        StDone
    } state_e;

    state_e             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_load_error;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   r_budget;
    logic [GPIO_W-1:0]  r_snapshot;
    logic [RST_W-1:0]   r_rst_cnt;

    logic               w_in_idle;
    logic               w_load_fire;
    logic               w_ptr_full;
    logic               w_ptr_zero;
    logic               w_start_ok;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_budget_hit;
    logic               w_halt_hit;
    logic               w_halted;

    assign w_in_idle    = (r_state == StIdle);
    assign w_load_fire  = io_seq.load_valid & w_in_idle;
    assign w_ptr_full   = (r_ptr == PTR_FULL);
    assign w_ptr_zero   = (r_ptr == '0);
    // A start coinciding with a load word is ignored so the program is never half-written.
    assign w_start_ok   = w_in_idle & io_seq.start & w_ptr_zero & ~w_load_fire;
    assign w_cnt_inc    = r_cycles + CNT_W'(1);
    assign w_budget_hit = (r_budget != '0) && (w_cnt_inc == r_budget);

`ifdef TINY_SEQ_HALT_DETECT_EN
    localparam int HW_W = $clog2(HALT_WINDOW + 1);

    logic [HW_W-1:0]   r_halt_cnt;
    logic [HW_W-1:0]   w_halt_next;
    logic [GPIO_W-1:0] r_prev_gpio;
    logic              r_prev_valid;
    logic              r_halted;
    logic              w_core_active;

    assign w_core_active = (r_state == StRun) || (r_state == StStep);

    // Length of the current streak of identical GPIO values, this cycle included.
    always_comb begin
        w_halt_next = HW_W'(1);
        if (r_prev_valid && (io_seq.proc_gpio_out == r_prev_gpio)) begin
            w_halt_next = r_halt_cnt + HW_W'(1);
        end
    end

    assign w_halt_hit = (w_halt_next == HW_W'(HALT_WINDOW));
    assign w_halted   = r_halted;

    always_ff @(posedge i_clock) begin
        if (i_reset_p) begin
            r_halt_cnt   <= '0;
            r_prev_gpio  <= '0;
            r_prev_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else if (w_start_ok) begin
            r_halt_cnt   <= '0;
            r_prev_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else if (w_core_active) begin
            r_halt_cnt   <= w_halt_next;
            r_prev_gpio  <= io_seq.proc_gpio_out;
            r_prev_valid <= 1'b1;
            if (w_halt_hit && !io_seq.stop) begin
                r_halted <= 1'b1;
            end
        end
    end
`else
    logic w_unused_halt_window;

    assign w_unused_halt_window = (HALT_WINDOW > 0);
    assign w_halt_hit           = 1'b0;
    assign w_halted             = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset_p) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_load_error <= 1'b0;
            r_cycles     <= '0;
            r_budget     <= '0;
            r_snapshot   <= '0;
            r_rst_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_load_fire) begin
                        if (w_ptr_full) begin
                            r_load_error <= 1'b1;
                        end else if (w_ptr_zero) begin
                            r_load_error <= 1'b0;
                        end
                        if (io_seq.load_last) begin
                            r_ptr <= '0;
                        end else if (!w_ptr_full) begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end
                    end
                    if (w_start_ok) begin
                        r_budget  <= io_seq.run_cycles;
                        r_cycles  <= '0;
                        r_rst_cnt <= '0;
                        r_state   <= StRst;
                    end
                end
                StRst: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state <= StRun;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                StRun: begin
                    r_cycles <= w_cnt_inc;
                    if (io_seq.stop || w_halt_hit || w_budget_hit) begin
                        r_state <= StDone;
                    end else if (io_seq.pause) begin
                        r_state <= StPause;
                    end
                end
                StPause: begin
                    if (io_seq.stop) begin
                        r_state <= StDone;
                    end else if (io_seq.step) begin
                        r_state <= StStep;
                    end else if (!io_seq.pause) begin
                        r_state <= StRun;
                    end
                end
                StStep: begin
                    r_cycles <= w_cnt_inc;
                    if (io_seq.stop || w_halt_hit || w_budget_hit) begin
                        r_state <= StDone;
                    end else begin
                        r_state <= StPause;
                    end
                end
                StDone: begin
                    r_snapshot <= io_seq.proc_gpio_out;
                    r_state    <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Core controls decode directly from the state register.
    assign io_seq.load_ready   = w_in_idle;
    assign io_seq.proc_reset_p = (r_state == StIdle) || (r_state == StRst);
    assign io_seq.proc_ce      = (r_state == StRst) || (r_state == StRun) || (r_state == StStep);
    assign io_seq.busy         = (r_state == StRst) || (r_state == StRun) ||
                                 (r_state == StPause) || (r_state == StStep);
    assign io_seq.done         = (r_state == StDone);

    assign io_seq.imem_we    = w_load_fire & ~w_ptr_full;
    assign io_seq.imem_addr  = r_ptr[ADDR_W-1:0];
    assign io_seq.imem_wdata = io_seq.load_data;

    assign io_seq.gpio_snapshot = r_snapshot;
    assign io_seq.cycles_run    = r_cycles;
    assign io_seq.load_error    = r_load_error;
    assign io_seq.halted        = w_halted;

endmodule

// File: tb/tb_tiny_proc_sequencer.sv
// Directed self-checking bench for tiny_proc_sequencer: load, overflow, budget run,
// pause/step, reset abort, back-to-back runs and (when enabled) halt detection.
module tb_tiny_proc_sequencer;

    logic clock   = 1'b0;
    logic reset_p = 1'b1;

    always #5 clock = ~clock;

    tiny_proc_sequencer_if #(
        .ADDR_W (4),
        .INSTR_W(8),
        .GPIO_W (4),
        .CNT_W  (16)
    ) seq_if ();

    tiny_proc_sequencer #(
        .ADDR_W     (4),
        .INSTR_W    (8),
        .GPIO_W     (4),
        .RST_CYCLES (3),
        .CNT_W      (16),
        .HALT_WINDOW(8)
    ) dut (
        .i_clock  (clock),
        .i_reset_p(reset_p),
        .io_seq   (seq_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [7:0] data, input logic last, output logic we,
                             output logic [3:0] addr, output logic [7:0] wdata);
        seq_if.load_valid = 1'b1;
        seq_if.load_data  = data;
        seq_if.load_last  = last;
        #1;
        we    = seq_if.imem_we;
        addr  = seq_if.imem_addr;
        wdata = seq_if.imem_wdata;
        tick();
        seq_if.load_valid = 1'b0;
        seq_if.load_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] budget);
        seq_if.start      = 1'b1;
        seq_if.run_cycles = budget;
        tick();
        seq_if.start = 1'b0;
    endtask

    // Samples the current cycle onward until the DONE cycle (left sampled) or the budget expires.
    task automatic observe(input int max_cycles, output int rst_hi, output int ce_hi,
                           output int done_cnt);
        rst_hi   = 0;
        ce_hi    = 0;
        done_cnt = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (seq_if.proc_reset_p && seq_if.busy) rst_hi++;
            if (seq_if.proc_ce) ce_hi++;
            if (seq_if.done) begin
                done_cnt++;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        tick();
        tick();
        reset_p = 1'b0;
        checks++;
        if (seq_if.busy !== 1'b0 || seq_if.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done got %b%b expected 00", seq_if.busy, seq_if.done);
        end
        checks++;
        if (seq_if.proc_reset_p !== 1'b1 || seq_if.proc_ce !== 1'b0 || seq_if.load_ready !== 1'b1)
        begin
            errors++;
            $display("FAIL reset_core got rst=%b ce=%b rdy=%b expected 1 0 1",
                     seq_if.proc_reset_p, seq_if.proc_ce, seq_if.load_ready);
        end
        checks++;
        if (seq_if.cycles_run !== 16'd0 || seq_if.gpio_snapshot !== 4'h0) begin
            errors++;
            $display("FAIL reset_counters got cyc=%0d snap=%0h expected 0 0",
                     seq_if.cycles_run, seq_if.gpio_snapshot);
        end
        checks++;
        if (seq_if.load_error !== 1'b0 || seq_if.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got err=%b halt=%b expected 0 0",
                     seq_if.load_error, seq_if.halted);
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] words [3];
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
        words = '{8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 3; i++) begin
            load_word(words[i], (i == 2), we, addr, wd);
            checks++;
            if (we !== 1'b1 || addr !== 4'(i) || wd !== words[i]) begin
                errors++;
                $display("FAIL load_basic[%0d] got we=%b addr=%0h data=%0h expected 1 %0h %0h",
                         i, we, addr, wd, i, words[i]);
            end
        end
        checks++;
        if (seq_if.load_error !== 1'b0) begin
            errors++;
            $display("FAIL load_basic_err got %b expected 0", seq_if.load_error);
        end
    endtask

    task automatic test_load_overflow();
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
        // The first word landing at address 0 also shows the pointer wrapped after load_last.
        for (int i = 0; i < 17; i++) begin
            load_word(8'(8'h40 + i), 1'b0, we, addr, wd);
            checks++;
            if (i < 16 && (we !== 1'b1 || addr !== 4'(i) || wd !== 8'(8'h40 + i))) begin
                errors++;
                $display("FAIL overflow_write[%0d] got we=%b addr=%0h expected 1 %0h",
                         i, we, addr, i);
            end else if (i == 16 && we !== 1'b0) begin
                errors++;
                $display("FAIL overflow_drop got we=%b expected 0", we);
            end
        end
        checks++;
        if (seq_if.load_error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err_set got %b expected 1", seq_if.load_error);
        end
        pulse_start(16'd5);
        checks++;
        if (seq_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ptr_nonzero got busy=%b expected 0", seq_if.busy);
        end
        load_word(8'hEE, 1'b1, we, addr, wd);
        checks++;
        if (we !== 1'b0 || seq_if.load_error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_last_drop got we=%b err=%b expected 0 1",
                     we, seq_if.load_error);
        end
        // Word at pointer 0 together with start: word is written, start is ignored.
        seq_if.start      = 1'b1;
        seq_if.run_cycles = 16'd5;
        load_word(8'hC0, 1'b1, we, addr, wd);
        seq_if.start = 1'b0;
        checks++;
        if (we !== 1'b1 || addr !== 4'h0 || wd !== 8'hC0) begin
            errors++;
            $display("FAIL reload_write got we=%b addr=%0h data=%0h expected 1 0 c0",
                     we, addr, wd);
        end
        checks++;
        if (seq_if.load_error !== 1'b0 || seq_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_clear got err=%b busy=%b expected 0 0",
                     seq_if.load_error, seq_if.busy);
        end
    endtask

    task automatic test_budget_run();
        int rst_hi, ce_hi, done_cnt;
        seq_if.proc_gpio_out = 4'h5;
        pulse_start(16'd10);
        observe(40, rst_hi, ce_hi, done_cnt);
        checks++;
        if (done_cnt !== 1 || rst_hi !== 3 || ce_hi !== 13) begin
            errors++;
            $display("FAIL budget_timing got done=%0d rst=%0d ce=%0d expected 1 3 13",
                     done_cnt, rst_hi, ce_hi);
        end
        checks++;
        if (seq_if.cycles_run !== 16'd10 || seq_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL budget_done_cycle got cyc=%0d busy=%b expected 10 0",
                     seq_if.cycles_run, seq_if.busy);
        end
        tick();
        checks++;
        if (seq_if.gpio_snapshot !== 4'h5 || seq_if.done !== 1'b0 || seq_if.busy !== 1'b0 ||
            seq_if.cycles_run !== 16'd10) begin
            errors++;
            $display("FAIL budget_after got snap=%0h done=%b busy=%b cyc=%0d expected 5 0 0 10",
                     seq_if.gpio_snapshot, seq_if.done, seq_if.busy, seq_if.cycles_run);
        end
    endtask

    task automatic test_pause_step();
        seq_if.proc_gpio_out = 4'h3;
        pulse_start(16'd0);
        repeat (6) tick();
        seq_if.pause = 1'b1;
        tick();
        repeat (2) tick();
        checks++;
        if (seq_if.cycles_run !== 16'd4 || seq_if.proc_ce !== 1'b0 || seq_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_freeze got cyc=%0d ce=%b busy=%b expected 4 0 1",
                     seq_if.cycles_run, seq_if.proc_ce, seq_if.busy);
        end
        for (int s = 0; s < 2; s++) begin
            seq_if.step = 1'b1;
            tick();
            seq_if.step = 1'b0;
            checks++;
            if (seq_if.proc_ce !== 1'b1 || seq_if.cycles_run !== 16'(4 + s)) begin
                errors++;
                $display("FAIL step%0d_active got ce=%b cyc=%0d expected 1 %0d",
                         s, seq_if.proc_ce, seq_if.cycles_run, 4 + s);
            end
            tick();
            checks++;
            if (seq_if.proc_ce !== 1'b0 || seq_if.cycles_run !== 16'(5 + s)) begin
                errors++;
                $display("FAIL step%0d_after got ce=%b cyc=%0d expected 0 %0d",
                         s, seq_if.proc_ce, seq_if.cycles_run, 5 + s);
            end
        end
        seq_if.stop = 1'b1;
        tick();
        seq_if.stop  = 1'b0;
        seq_if.pause = 1'b0;
        checks++;
        if (seq_if.done !== 1'b1 || seq_if.cycles_run !== 16'd6) begin
            errors++;
            $display("FAIL stop_done got done=%b cyc=%0d expected 1 6",
                     seq_if.done, seq_if.cycles_run);
        end
        tick();
        checks++;
        if (seq_if.done !== 1'b0 || seq_if.busy !== 1'b0 || seq_if.gpio_snapshot !== 4'h3) begin
            errors++;
            $display("FAIL stop_after got done=%b busy=%b snap=%0h expected 0 0 3",
                     seq_if.done, seq_if.busy, seq_if.gpio_snapshot);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        seq_if.proc_gpio_out = 4'h9;
        pulse_start(16'd0);
        repeat (10) tick();
        checks++;
        if (seq_if.cycles_run !== 16'd7 || seq_if.proc_ce !== 1'b1 ||
            seq_if.proc_reset_p !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got cyc=%0d ce=%b rst=%b expected 7 1 0",
                     seq_if.cycles_run, seq_if.proc_ce, seq_if.proc_reset_p);
        end
        reset_p = 1'b1;
        tick();
        reset_p = 1'b0;
        checks++;
        if (seq_if.proc_reset_p !== 1'b1 || seq_if.proc_ce !== 1'b0 || seq_if.busy !== 1'b0 ||
            seq_if.cycles_run !== 16'd0 || seq_if.gpio_snapshot !== 4'h0) begin
            errors++;
            $display("FAIL abort_state got rst=%b ce=%b busy=%b cyc=%0d snap=%0h expected 1 0 0 0 0",
                     seq_if.proc_reset_p, seq_if.proc_ce, seq_if.busy, seq_if.cycles_run,
                     seq_if.gpio_snapshot);
        end
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (seq_if.done) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d expected 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int rst_hi, ce_hi, done_cnt;
        seq_if.proc_gpio_out = 4'hC;
        pulse_start(16'd1);
        observe(20, rst_hi, ce_hi, done_cnt);
        checks++;
        if (done_cnt !== 1 || ce_hi !== 4 || seq_if.cycles_run !== 16'd1) begin
            errors++;
            $display("FAIL budget1 got done=%0d ce=%0d cyc=%0d expected 1 4 1",
                     done_cnt, ce_hi, seq_if.cycles_run);
        end
        tick();
        checks++;
        if (seq_if.gpio_snapshot !== 4'hC) begin
            errors++;
            $display("FAIL budget1_snap got %0h expected c", seq_if.gpio_snapshot);
        end
        pulse_start(16'd2);
        // stop during RST must be ignored.
        seq_if.stop = 1'b1;
        tick();
        seq_if.stop = 1'b0;
        checks++;
        if (seq_if.busy !== 1'b1 || seq_if.proc_reset_p !== 1'b1) begin
            errors++;
            $display("FAIL stop_in_rst got busy=%b rst=%b expected 1 1",
                     seq_if.busy, seq_if.proc_reset_p);
        end
        observe(20, rst_hi, ce_hi, done_cnt);
        checks++;
        if (done_cnt !== 1 || rst_hi !== 2 || ce_hi !== 4 || seq_if.cycles_run !== 16'd2) begin
            errors++;
            $display("FAIL budget2 got done=%0d rst=%0d ce=%0d cyc=%0d expected 1 2 4 2",
                     done_cnt, rst_hi, ce_hi, seq_if.cycles_run);
        end
        tick();
    endtask

`ifdef TINY_SEQ_HALT_DETECT_EN
    task automatic test_halt();
        int rst_hi, ce_hi, done_cnt;
        seq_if.proc_gpio_out = 4'hA;
        pulse_start(16'd0);
        observe(60, rst_hi, ce_hi, done_cnt);
        checks++;
        if (done_cnt !== 1 || ce_hi !== 11 || seq_if.cycles_run !== 16'd8) begin
            errors++;
            $display("FAIL halt_run got done=%0d ce=%0d cyc=%0d expected 1 11 8",
                     done_cnt, ce_hi, seq_if.cycles_run);
        end
        tick();
        checks++;
        if (seq_if.halted !== 1'b1 || seq_if.gpio_snapshot !== 4'hA) begin
            errors++;
            $display("FAIL halt_flag got halted=%b snap=%0h expected 1 a",
                     seq_if.halted, seq_if.gpio_snapshot);
        end
        pulse_start(16'd1);
        checks++;
        if (seq_if.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear got %b expected 0", seq_if.halted);
        end
        observe(20, rst_hi, ce_hi, done_cnt);
        tick();
    endtask
`else
    task automatic test_halt();
        checks++;
        if (seq_if.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_tied got %b expected 0", seq_if.halted);
        end
    endtask
`endif

    initial begin
        seq_if.load_valid    = 1'b0;
        seq_if.load_data     = 8'h00;
        seq_if.load_last     = 1'b0;
        seq_if.start         = 1'b0;
        seq_if.run_cycles    = 16'd0;
        seq_if.pause         = 1'b0;
        seq_if.step          = 1'b0;
        seq_if.stop          = 1'b0;
        seq_if.proc_gpio_out = 4'h0;
        test_reset();
        test_load_basic();
        test_load_overflow();
        test_budget_run();
        test_pause_step();
        test_reset_abort();
        test_back_to_back();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/tiny_proc_sequencer.md
Name: tiny_proc_sequencer

Overview:
Run controller for the 4-bit tiny processor. It loads a program into the processor's 16-word instruction memory and holds the core in reset while loading. It then releases reset, gates the core clock-enable for run, pause and single-step, and counts executed cycles. On completion it snapshots the GPIO output so a host or bench can drive a full program run from one start pulse.

Parameters:
ADDR_W, 4, instruction-memory address width (depth 2^ADDR_W)
INSTR_W, 8, instruction word width
GPIO_W, 4, processor GPIO width
RST_CYCLES, 3, cycles proc_reset_p is held high in RST state (>=1)
CNT_W, 16, cycle counter / budget width
HALT_WINDOW, 8, stable-GPIO cycles for halt detect (optional feature only)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_p  in  1  synchronous active-high reset
load_valid  in  1  program word valid
load_data  in  INSTR_W  program word
load_last  in  1  marks final word of program
load_ready  out  1  word accepted when load_valid & load_ready
start  in  1  one-cycle run request
run_cycles  in  CNT_W  cycle budget, sampled on accepted start; 0 = unlimited
pause  in  1  level: hold core while high
step  in  1  one-cycle pulse: advance one cycle while paused
stop  in  1  one-cycle pulse: end run
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  write address
imem_wdata  out  INSTR_W  write data
proc_reset_p  out  1  reset to processor core
proc_ce  out  1  clock enable to processor core
proc_gpio_out  in  GPIO_W  processor GPIO output
gpio_snapshot  out  GPIO_W  proc_gpio_out captured at run end
cycles_run  out  CNT_W  enabled cycles in current/last run
busy  out  1  high in RST/RUN/PAUSE/STEP
done  out  1  one-cycle pulse at run end
load_error  out  1  sticky: program overflowed memory
halted  out  1  halt-detect flag (0 without optional feature)

Behaviour:
- Reset (reset_p=1 at edge): state IDLE, load pointer 0, load_error 0, cycles_run 0, gpio_snapshot 0, done 0, halted 0. Applies from any state; an in-progress run is aborted with no done pulse.
- States: IDLE, RST, RUN, PAUSE, STEP, DONE. Outputs are decoded from the registered state. imem_* are combinational from load handshake.
- IDLE:
  - proc_reset_p=1, proc_ce=0, load_ready=1, busy=0.
  - Accepted word: if pointer < 2^ADDR_W, imem_we=1 same cycle, imem_addr=pointer, imem_wdata=load_data, pointer++.
  - If pointer == 2^ADDR_W, the word is dropped (imem_we=0) and load_error is set.
  - Accepted word with load_last: pointer<=0 after the write. load_error holds until the next accepted word at pointer 0, then clears.
  - start is accepted only when pointer==0 and no load handshake occurs that cycle; otherwise start is ignored. On accept: latch run_cycles, cycles_run<=0, go RST.
- RST: proc_reset_p=1, proc_ce=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: proc_reset_p=0, proc_ce=1, cycles_run++ every cycle (wraps mod 2^CNT_W). Exit priority, evaluated at the edge after the counted cycle:
  - stop -> DONE;
  - budget!=0 and cycles_run+1==budget -> DONE;
  - pause -> PAUSE;
  - else stay.
- PAUSE: proc_ce=0, counter frozen. Exit priority: stop -> DONE; step -> STEP; pause low -> RUN.
- STEP: proc_ce=1 one cycle, cycles_run++. Then DONE if stop or budget reached, else PAUSE.
- DONE (one cycle):
  - proc_reset_p=0, proc_ce=0, done=1.
  - gpio_snapshot<=proc_gpio_out at that edge.
  - Next state IDLE. cycles_run and gpio_snapshot hold until the next accepted start.
- start, step or stop outside the states that use them are ignored.

Optional Feature:
TINY_SEQ_HALT_DETECT_EN
- Defined: in RUN/STEP a counter tracks consecutive enabled cycles with proc_gpio_out unchanged. It resets on any change and on run start. Reaching HALT_WINDOW forces DONE (priority below stop, above budget) and sets halted=1. halted clears on the next accepted start.
- Undefined: no counter, halted tied 0, runs end only by stop or budget.

Test Plan:
1. Load 0xB1,0xB2,0xB3, last on third -> imem writes (0,B1),(1,B2),(2,B3); load_error=0; pointer back to 0.
2. Load 17 words, no last -> 16 writes addr 0..15; 17th has imem_we=0; load_error=1 until next load starting at pointer 0.
3. start, run_cycles=10, proc_gpio_out=4'h5 -> proc_reset_p high 3 cycles after IDLE exit; proc_ce high 13 cycles (3 RST + 10 RUN); done pulse; cycles_run=10; gpio_snapshot=4'h5; busy low after DONE.
4. start, run_cycles=0, pause raised so cycles_run freezes at 4, two step pulses, then stop -> proc_ce high exactly one cycle per step; cycles_run=6; one done pulse.
5. reset_p for one cycle at cycles_run=7 in RUN -> next cycle IDLE, proc_reset_p=1, proc_ce=0, cycles_run=0, busy=0, no done pulse.
6. With TINY_SEQ_HALT_DETECT_EN, run_cycles=0, proc_gpio_out constant 4'hA from first RUN cycle -> done after 8 RUN cycles, halted=1, gpio_snapshot=4'hA.
